// File: rtl/run_ctrl_monitor.sv
// Run-control unit: detects halt (or watchdog expiry), drains the pipe, freezes the core,
// then streams X0..X(NREGS-1) out over a valid/ready port.
module run_ctrl_monitor #(
    parameter int                 INSTR_W      = 32,
    parameter int                 DATA_W       = 64,
    parameter int                 NREGS        = 20,
    parameter int                 REG_AW       = 5,
    parameter int                 DRAIN_CYCLES = 8,
    parameter int                 MAX_CYCLES   = 5000,
    parameter int                 CYC_W        = 32,
    parameter logic [INSTR_W-1:0] HALT_MASK    = 32'hFFFF_FFFF,
    parameter logic [INSTR_W-1:0] HALT_MATCH   = 32'h1400_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic               flush,
    input  logic               sw_halt,
    input  logic               clear,
    output logic [REG_AW-1:0]  rf_raddr,
    input  logic [DATA_W-1:0]  rf_rdata,
    output logic               cpu_freeze,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [REG_AW-1:0]  dump_idx,
    output logic [DATA_W-1:0]  dump_data,
    output logic               dump_last,
    output logic               halted,
    output logic               timeout,
    output logic               done,
    output logic [CYC_W-1:0]   cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DUMP_RD,
        S_DUMP_TX,
        S_DONE
    } state_t;

    localparam int                DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CYC_W-1:0]   MAX_LAST   = CYC_W'(MAX_CYCLES - 1);
    localparam logic [REG_AW-1:0]  LAST_IDX   = REG_AW'(NREGS - 1);

    state_t             state, state_nx;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [REG_AW-1:0]  idx;
    logic               halt_hit;
    logic               at_limit;
    logic               last_beat;
    logic               counting;

    // A halt sitting in a squashed fetch slot never architecturally executes.
    assign halt_hit  = sw_halt | (instr_valid & ~flush & ((instr & HALT_MASK) == HALT_MATCH));
    assign at_limit  = (cycle_count == MAX_LAST);
    assign last_beat = (idx == LAST_IDX);
    assign counting  = (state == S_RUN) || (state == S_DRAIN);
    assign rf_raddr  = idx;
    assign dump_last = dump_valid & (dump_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        cpu_freeze = 1'b0;
        dump_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (instr_valid) state_nx = S_RUN;
            end
            S_RUN: begin
                // Halt takes priority over a watchdog expiring in the same cycle.
                if (halt_hit)      state_nx = (DRAIN_CYCLES == 0) ? S_DUMP_RD : S_DRAIN;
                else if (at_limit) state_nx = S_DUMP_RD;
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_nx = S_DUMP_RD;
            end
            S_DUMP_RD: begin
                cpu_freeze = 1'b1;
                state_nx   = S_DUMP_TX;
            end
            S_DUMP_TX: begin
                cpu_freeze = 1'b1;
                dump_valid = 1'b1;
                if (dump_ready) state_nx = last_beat ? S_DONE : S_DUMP_RD;
            end
            S_DONE: begin
                cpu_freeze = 1'b1;
                if (clear) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            drain_cnt   <= '0;
            idx         <= '0;
            dump_idx    <= '0;
            dump_data   <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (counting && (cycle_count != {CYC_W{1'b1}}))
                cycle_count <= cycle_count + CYC_W'(1);

            if (state == S_DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
            else                  drain_cnt <= '0;

            if (state == S_RUN) begin
                if (halt_hit)      halted  <= 1'b1;
                else if (at_limit) timeout <= 1'b1;
            end

            // Capture is one cycle after the address is presented, so the beat
            // registers stay put for the whole DUMP_TX backpressure window.
            if (state == S_DUMP_RD) begin
                dump_data <= rf_rdata;
                dump_idx  <= idx;
            end

            if ((state == S_DUMP_TX) && dump_ready) begin
                if (last_beat) done <= 1'b1;
                else           idx  <= idx + REG_AW'(1);
            end

            if ((state == S_DONE) && clear) begin
                cycle_count <= '0;
                idx         <= '0;
                halted      <= 1'b0;
                timeout     <= 1'b0;
                done        <= 1'b0;
            end
        end
    end

endmodule
